bp_train_seq: RTL and testbench
===============================

# bp_train_seq

Training-loop sequencer for the backpropagation datapath (`bp`). It steps a sample index through a batch, gives each sample a fixed forward-settle window, drives `bp`'s `accu` strobe for a fixed accumulate window, and pulses `cost_rst` at the start of every epoch. It pulses a weight-update commit at the end of every epoch and repeats for a programmed number of epochs. It sits between the top-level training control (start/abort) and the `bp` instance plus the sample store that supplies `i_k`, `i_t` and activations.

## Interface

Parameters:

- `N_SAMPLE`, 4, samples per epoch (≥1)
- `IDXW`, 2, width of sample index; 2^IDXW ≥ N_SAMPLE
- `EPW`, 16, width of epoch count
- `FWD_CYC`, 2, forward-settle cycles per sample (≥1)
- `ACC_CYC`, 2, cycles `accu` is held high per sample (≥1)

Ports:

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_start`  in  1  start training; sampled only in IDLE
- `i_abort`  in  1  abort; takes priority over everything except reset
- `i_n_epoch`  in  EPW  epochs to run; latched on accepted start
- `o_busy`  out  1  high in CLR/FWD/ACC/UPD
- `o_done`  out  1  one-cycle pulse on normal completion
- `o_cost_rst`  out  1  to `bp.cost_rst`; high one cycle per epoch
- `o_accu`  out  1  to `bp.accu`
- `o_upd`  out  1  one-cycle weight-commit pulse at end of epoch
- `o_idx`  out  IDXW  current sample index to the sample store
- `o_epoch`  out  EPW  epochs completed since last start

## Operation

- Moore FSM with states IDLE, CLR, FWD, ACC, UPD, DONE. All outputs are decoded from registered state and counters. There is no combinational input-to-output path.
- IDLE: all outputs 0.
  - `i_start`=1 and `i_abort`=0: latch `i_n_epoch`, clear `o_epoch`, set idx=0.
  - Go to DONE if latched count is 0, else go to CLR.
  - `i_start` in any other state is ignored.
- CLR: `o_cost_rst`=1, idx=0. Next state is FWD.
- FWD: hold idx, `o_accu`=0. Phase counter runs FWD_CYC cycles, then go to ACC.
- ACC: `o_accu`=1 for ACC_CYC cycles. Then:
  - if idx==N_SAMPLE-1, go to UPD;
  - else idx+1 and go to FWD.
- UPD: `o_upd`=1 for one cycle and `o_epoch`+1.
  - If the new `o_epoch` equals the latched count, go to DONE.
  - Else go to CLR.
- DONE: `o_done`=1 for one cycle. Next state is IDLE.
- Abort: `i_abort`=1 in any state other than IDLE goes to IDLE next cycle.
  - No `o_done`, no `o_upd` from that cycle on.
  - `o_idx` returns to 0.
  - `o_epoch` holds its partial count.
- `o_epoch` holds its value in IDLE after completion until the next accepted start.
- Arithmetic:
  - The epoch counter is unsigned EPW bits and does not wrap, since it stops at the latched count.
  - The phase counter is wide enough for max(FWD_CYC, ACC_CYC).
  - The index counter is IDXW bits and never exceeds N_SAMPLE-1.

## Timing

- Reset (`rst`=0, async): state IDLE. All outputs 0, including `o_idx`, `o_epoch`, `o_busy`, `o_done`.
- Deassertion takes effect at the first rising edge with `rst`=1.
- Start accepted at edge k: CLR occupies cycle k+1.
- Epoch length E = 2 + N_SAMPLE·(FWD_CYC+ACC_CYC) cycles (CLR + samples + UPD). Default E = 18.
- With start at edge k, `o_done` is high in cycle k+1+n·E for n = latched epoch count. Default n=3 gives cycle k+55.
- n=0: `o_done` is high in cycle k+1. No CLR, no `o_upd`.
- `o_idx` is stable for the whole FWD+ACC window of its sample and changes on the edge leaving ACC.
- `o_accu` is never high in the same cycle as `o_cost_rst` or `o_upd`.
- `o_busy` is low during DONE, so the next start can be accepted the cycle after DONE (back-to-back runs).
- Start and abort asserted together in IDLE: start is ignored.

## Test plan

- Reset mid-ACC (epoch 1, idx 2), then release → all outputs 0 immediately, still 0 the cycle after release; a new start behaves normally.
- Defaults, `i_n_epoch`=3, start pulse at edge k → `o_cost_rst` at k+1, k+19, k+37; `o_accu` high 2 of every 4 cycles; `o_idx` 0,1,2,3 per epoch; `o_upd` at k+18, k+36, k+54; `o_done` at k+55; `o_epoch`=3 afterwards.
- `i_n_epoch`=0 → `o_done` one cycle after start; `o_cost_rst`, `o_accu`, `o_upd` never assert; `o_epoch`=0.
- `i_abort` during epoch 2 ACC → IDLE next cycle, `o_accu`=0, `o_idx`=0, `o_epoch`=1, no `o_done`; `i_start` during the run never restarts it.
- FWD_CYC=1, ACC_CYC=3, N_SAMPLE=1, `i_n_epoch`=2 → E=6, `o_done` at k+13; `o_done` followed immediately by a new start is accepted the next cycle.

Source files
------------

// File: rtl/bp_train_seq.sv
// bp_train_seq: training-loop sequencer for the backpropagation datapath.
// Walks a sample index through each batch, gives every sample a forward-settle
// window followed by an accumulate window, and brackets each epoch with a
// cost reset (CLR) and a weight-commit pulse (UPD). Repeats for the epoch
// count latched at start. All outputs are decoded from registered state.
module bp_train_seq #(
    parameter int N_SAMPLE = 4,
    parameter int IDXW     = 2,
    parameter int EPW      = 16,
    parameter int FWD_CYC  = 2,
    parameter int ACC_CYC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [EPW-1:0]  i_n_epoch,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_cost_rst,
    output logic            o_accu,
    output logic            o_upd,
    output logic [IDXW-1:0] o_idx,
    output logic [EPW-1:0]  o_epoch
);

    // Phase counter only has to count up to the longer of the two windows.
    localparam int PMAX = (FWD_CYC > ACC_CYC) ? FWD_CYC : ACC_CYC;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [PW-1:0]   FWD_LAST = PW'(FWD_CYC - 1);
    localparam logic [PW-1:0]   ACC_LAST = PW'(ACC_CYC - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_SAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FWD,
        S_ACC,
        S_UPD,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   phase_reg, phase_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [EPW-1:0]  epoch_reg, epoch_next;
    logic [EPW-1:0]  n_epoch_reg, n_epoch_next;
    logic [EPW-1:0]  epoch_inc;

    assign epoch_inc = epoch_reg + EPW'(1);

    // State and counter registers; async active-low reset returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            phase_reg   <= '0;
            idx_reg     <= '0;
            epoch_reg   <= '0;
            n_epoch_reg <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            idx_reg     <= idx_next;
            epoch_reg   <= epoch_next;
            n_epoch_reg <= n_epoch_next;
        end
    end

    // Next-state and counter update; abort overrides every non-IDLE state.
    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        idx_next     = idx_reg;
        epoch_next   = epoch_reg;
        n_epoch_next = n_epoch_reg;

        case (state_reg)
            S_IDLE: begin
                phase_next = '0;
                idx_next   = '0;
                if (i_start && !i_abort) begin
                    n_epoch_next = i_n_epoch;
                    epoch_next   = '0;
                    state_next   = (i_n_epoch == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                phase_next = '0;
                idx_next   = '0;
                state_next = S_FWD;
            end
            S_FWD: begin
                if (phase_reg == FWD_LAST) begin
                    phase_next = '0;
                    state_next = S_ACC;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            S_ACC: begin
                if (phase_reg == ACC_LAST) begin
                    phase_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        // Index parks at 0 once the batch is exhausted.
                        idx_next   = '0;
                        state_next = S_UPD;
                    end else begin
                        idx_next   = idx_reg + IDXW'(1);
                        state_next = S_FWD;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            S_UPD: begin
                // Epoch count advances on the edge leaving the commit cycle.
                epoch_next = epoch_inc;
                state_next = (epoch_inc == n_epoch_reg) ? S_DONE : S_CLR;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                phase_next = '0;
                idx_next   = '0;
            end
        endcase

        if (i_abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            phase_next = '0;
            idx_next   = '0;
            epoch_next = epoch_reg;
        end
    end

    // Moore output decode from registered state and counters.
    always_comb begin
        o_busy     = (state_reg == S_CLR) || (state_reg == S_FWD) ||
                     (state_reg == S_ACC) || (state_reg == S_UPD);
        o_done     = (state_reg == S_DONE);
        o_cost_rst = (state_reg == S_CLR);
        o_accu     = (state_reg == S_ACC);
        o_upd      = (state_reg == S_UPD);
        o_idx      = idx_reg;
        o_epoch    = epoch_reg;
    end

endmodule

// File: tb/tb_bp_train_seq.sv
// tb_bp_train_seq: directed bench for bp_train_seq. Instance a uses the default
// parameters; instance b uses FWD_CYC=1, ACC_CYC=3, N_SAMPLE=1.
module tb_bp_train_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic        a_start, a_abort;
    logic [15:0] a_n;
    logic        a_busy, a_done, a_cr, a_accu, a_upd;
    logic [1:0]  a_idx;
    logic [15:0] a_epoch;

    logic        b_start, b_abort;
    logic [15:0] b_n;
    logic        b_busy, b_done, b_cr, b_accu, b_upd;
    logic [0:0]  b_idx;
    logic [15:0] b_epoch;

    bp_train_seq dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_start    (a_start),
        .i_abort    (a_abort),
        .i_n_epoch  (a_n),
        .o_busy     (a_busy),
        .o_done     (a_done),
        .o_cost_rst (a_cr),
        .o_accu     (a_accu),
        .o_upd      (a_upd),
        .o_idx      (a_idx),
        .o_epoch    (a_epoch)
    );

    bp_train_seq #(
        .N_SAMPLE (1),
        .IDXW     (1),
        .EPW      (16),
        .FWD_CYC  (1),
        .ACC_CYC  (3)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_start    (b_start),
        .i_abort    (b_abort),
        .i_n_epoch  (b_n),
        .o_busy     (b_busy),
        .o_done     (b_done),
        .o_cost_rst (b_cr),
        .o_accu     (b_accu),
        .o_upd      (b_upd),
        .o_idx      (b_idx),
        .o_epoch    (b_epoch)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [15:0] n;
        int          extra;
        logic        busy;
        logic        done;
        logic        cr;
        logic        accu;
        logic        upd;
        logic [1:0]  idx;
        logic [15:0] ep;
    } vec_t;

    vec_t vecs[9];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic busy, input logic done, input logic cr,
                         input logic accu, input logic upd, input logic [1:0] idx,
                         input logic [15:0] ep);
        chk({tag, ".busy"},     a_busy,  busy);
        chk({tag, ".done"},     a_done,  done);
        chk({tag, ".cost_rst"}, a_cr,    cr);
        chk({tag, ".accu"},     a_accu,  accu);
        chk({tag, ".upd"},      a_upd,   upd);
        chk({tag, ".idx"},      a_idx,   idx);
        chk({tag, ".epoch"},    a_epoch, ep);
    endtask

    task automatic chk_b(input string tag, input logic busy, input logic done, input logic cr,
                         input logic accu, input logic upd, input logic [15:0] ep);
        chk({tag, ".busy"},     b_busy,  busy);
        chk({tag, ".done"},     b_done,  done);
        chk({tag, ".cost_rst"}, b_cr,    cr);
        chk({tag, ".accu"},     b_accu,  accu);
        chk({tag, ".upd"},      b_upd,   upd);
        chk({tag, ".idx"},      b_idx,   1'b0);
        chk({tag, ".epoch"},    b_epoch, ep);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic e_busy, e_done, e_cr, e_accu, e_upd;
        logic [1:0]  e_idx;
        logic [15:0] e_ep;
        int p, s, q;

        // start, abort, n, extra edges, busy, done, cost_rst, accu, upd, idx, epoch
        vecs[0] = '{1'b1, 1'b1, 16'd5, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3};
        vecs[1] = '{1'b0, 1'b0, 16'd5, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3};
        vecs[2] = '{1'b1, 1'b0, 16'd0, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 16'd0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
        vecs[4] = '{1'b1, 1'b0, 16'd3, 0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 16'd7, 8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'd0};
        vecs[6] = '{1'b1, 1'b0, 16'd7, 19, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'd1};
        vecs[7] = '{1'b0, 1'b1, 16'd7, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1};
        vecs[8] = '{1'b0, 1'b0, 16'd7, 30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1};

        a_start = 1'b0; a_abort = 1'b0; a_n = 16'd0;
        b_start = 1'b0; b_abort = 1'b0; b_n = 16'd0;

        // Reset state, then release.
        step();
        step();
        chk_a("reset", 0, 0, 0, 0, 0, 2'd0, 16'd0);
        rst = 1'b1;
        step();
        chk_a("post_reset", 0, 0, 0, 0, 0, 2'd0, 16'd0);
        $display("reset: busy=%0b epoch=%0d", a_busy, a_epoch);

        // Reset asserted mid-ACC of the first epoch, sample 2.
        a_n = 16'd3; a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (11) step();
        chk_a("pre_rst", 1, 0, 0, 1, 0, 2'd2, 16'd0);
        #1 rst = 1'b0;
        #1;
        chk_a("rst_async", 0, 0, 0, 0, 0, 2'd0, 16'd0);
        step();
        rst = 1'b1;
        step();
        chk_a("rst_release", 0, 0, 0, 0, 0, 2'd0, 16'd0);
        $display("mid-run reset: busy=%0b accu=%0b idx=%0d", a_busy, a_accu, a_idx);

        // Full default run, n=3: check every cycle from k+1 to k+56.
        a_n = 16'd3; a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int t = 1; t <= 56; t++) begin
            e_busy = 0; e_done = 0; e_cr = 0; e_accu = 0; e_upd = 0;
            e_idx = 2'd0; e_ep = 16'd3;
            if (t <= 54) begin
                e_busy = 1;
                e_ep = 16'((t - 1) / 18);
                p = (t - 1) % 18;
                e_cr  = (p == 0);
                e_upd = (p == 17);
                if (p >= 1 && p <= 16) begin
                    s = (p - 1) / 4;
                    q = (p - 1) % 4;
                    e_accu = (q >= 2);
                    e_idx  = 2'(s);
                end
            end else if (t == 55) begin
                e_done = 1;
            end
            chk_a($sformatf("run_t%0d", t), e_busy, e_done, e_cr, e_accu, e_upd, e_idx, e_ep);
            if (t < 56) step();
        end
        $display("default run n=3: done seen, epoch=%0d", a_epoch);

        // Table: start+abort in IDLE, n=0, start ignored while busy, abort.
        for (int i = 0; i < 9; i++) begin
            a_start = vecs[i].start;
            a_abort = vecs[i].abort;
            a_n     = vecs[i].n;
            step();
            a_start = 1'b0;
            a_abort = 1'b0;
            repeat (vecs[i].extra) step();
            chk_a($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done, vecs[i].cr,
                  vecs[i].accu, vecs[i].upd, vecs[i].idx, vecs[i].ep);
            $display("vec %0d start=%0b abort=%0b n=%0d -> busy=%0b done=%0b idx=%0d epoch=%0d",
                     i, vecs[i].start, vecs[i].abort, vecs[i].n, a_busy, a_done, a_idx, a_epoch);
        end

        // Instance b: E=6, n=2, done at k+13, then back-to-back start.
        b_n = 16'd2; b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int t = 1; t <= 13; t++) begin
            e_busy = (t <= 12);
            e_done = (t == 13);
            e_cr   = (t == 1) || (t == 7);
            e_accu = (t >= 3 && t <= 5) || (t >= 9 && t <= 11);
            e_upd  = (t == 6) || (t == 12);
            e_ep   = (t <= 6) ? 16'd0 : ((t <= 12) ? 16'd1 : 16'd2);
            chk_b($sformatf("b_t%0d", t), e_busy, e_done, e_cr, e_accu, e_upd, e_ep);
            if (t < 13) step();
        end
        step();
        chk_b("b_idle", 0, 0, 0, 0, 0, 16'd2);
        b_n = 16'd1; b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk_b("b_restart", 1, 0, 1, 0, 0, 16'd0);
        repeat (6) step();
        chk_b("b_done2", 0, 1, 0, 0, 0, 16'd1);
        $display("short config: second run done=%0b epoch=%0d", b_done, b_epoch);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
